mul_accumulator: RTL

Sequential multiply-accumulate back end that consumes the 8-bit products of the gate-level 8-bit multiplier and sums a programmed number of them into a wide accumulator. A single start command sets up a run of `len` products. Products are accepted one per cycle over a valid/ready handshake. The final sum is presented on an output handshake port to the CPU writeback path.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_acc_add.sv | 35 +++
 rtl/mul_accumulator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-accumulate back end: FSM encoding and
// default widths.
package mul_pkg;

    localparam int MUL_ACC_W = 16;
    localparam int MUL_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mul_acc_state_t;

endpackage

// File: rtl/mul_acc_add.sv
// Accumulator adder: ACC_W-bit sum plus an unsigned 8-bit product, with carry out.
// Define MUL_ACC_SATURATE_EN to clamp the result to all-ones on carry instead of wrapping.
module mul_acc_add
    import mul_pkg::*;
#(
    parameter int ACC_W = MUL_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [7:0]       product,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] sum_s;

    // Widened sum; the top bit is the carry out of the accumulator width.
    always_comb begin
        sum_s = {1'b0, acc} + {{(ACC_W-7){1'b0}}, product};
        carry = sum_s[ACC_W];
    end

    // Next accumulator value: clamp on carry when saturating, otherwise wrap.
    always_comb begin
`ifdef MUL_ACC_SATURATE_EN
        if (sum_s[ACC_W]) begin
            acc_next = {ACC_W{1'b1}};
        end else begin
            acc_next = sum_s[ACC_W-1:0];
        end
`else
        acc_next = sum_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mul_accumulator.sv
// Sequential multiply-accumulate back end: sums `len` 8-bit products per run.
// Build option MUL_ACC_SATURATE_EN selects saturating instead of wrapping sums.
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int ACC_W = MUL_ACC_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    mul_acc_state_t   state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [ACC_W-1:0] acc_next_s;
    logic             carry_s;
    logic             beat_s;

    mul_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc_r),
        .product  (in_product),
        .acc_next (acc_next_s),
        .carry    (carry_s)
    );

    // A beat needs the registered ready, so ready never depends on in_valid.
    always_comb begin
        beat_s = in_valid & in_ready_r;
    end

    // Run-control FSM with its datapath registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r  <= {ACC_W{1'b0}};
                        ovf_r  <= 1'b0;
                        busy_r <= 1'b1;
                        if (len != {CNT_W{1'b0}}) begin
                            cnt_r      <= len;
                            in_ready_r <= 1'b1;
                            state_r    <= ACCUM;
                        end else begin
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        acc_r <= acc_next_s;
                        ovf_r <= ovf_r | carry_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        // The beat taken at a count of one closes the run.
                        if (cnt_r == CNT_W'(1)) begin
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_acc   = acc_r;
    assign out_ovf   = ovf_r;
    assign busy      = busy_r;

endmodule
